// File: rtl/ram512_fifo_pkg.sv
// Shared sizing constants for the 512x8 RAM-backed FIFO controller.
package ram512_fifo_pkg;

   localparam int RAM512_AW       = 9;
   localparam int RAM512_DW       = 8;
   localparam int RAM512_DEPTH    = 2 ** RAM512_AW;
   localparam int RAM512_AF_LEVEL = 448;
   localparam int RAM512_AE_LEVEL = 64;

endpackage

// File: rtl/ram512_fifo_ctrl_if.sv
// Push/pop byte interface and status of the FIFO controller.
// almost_full/almost_empty exist only with RAM512_FIFO_ALMOST_FLAGS_EN.
interface ram512_fifo_ctrl_if
   import ram512_fifo_pkg::*;
#(
   parameter int AW = RAM512_AW,
   parameter int DW = RAM512_DW
);
   logic          push;
   logic [DW-1:0] wr_data;
   logic          pop;
   logic [DW-1:0] rd_data;
   logic          rd_valid;
   logic          flush;
   logic          clr_flags;
   logic          full;
   logic          empty;
   logic [AW:0]   level;
   logic          overflow;
   logic          underflow;
`ifdef RAM512_FIFO_ALMOST_FLAGS_EN
   logic          almost_full;
   logic          almost_empty;
`endif

   modport master (
      output push, wr_data, pop, flush, clr_flags,
      input  rd_data, rd_valid, full, empty, level, overflow, underflow
`ifdef RAM512_FIFO_ALMOST_FLAGS_EN
      , input almost_full, almost_empty
`endif
   );

   modport slave (
      input  push, wr_data, pop, flush, clr_flags,
      output rd_data, rd_valid, full, empty, level, overflow, underflow
`ifdef RAM512_FIFO_ALMOST_FLAGS_EN
      , output almost_full, almost_empty
`endif
   );
endinterface

// File: rtl/fifo_ptr_cnt.sv
// Wrapping W-bit FIFO pointer (MSB is the wrap bit) with synchronous clear.
module fifo_ptr_cnt #(
   parameter int W = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] ptr,
   output logic [W-1:0] ptr_nxt
);
   logic [W-1:0] ptr_q, ptr_d;

   always_comb begin
      ptr_d = ptr_q;
      if (clr)      ptr_d = '0;
      else if (inc) ptr_d = ptr_q + {{(W-1){1'b0}}, 1'b1};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) ptr_q <= '0;
      else     ptr_q <= ptr_d;
   end

   assign ptr     = ptr_q;
   assign ptr_nxt = ptr_d;
endmodule

// File: rtl/ram512_fifo_ctrl.sv
// FIFO controller sequencing an external 512x8 block RAM with one-cycle read latency.
// Optional almost flags: define RAM512_FIFO_ALMOST_FLAGS_EN.
module ram512_fifo_ctrl
   import ram512_fifo_pkg::*;
#(
   parameter int AW       = RAM512_AW,
   parameter int DW       = RAM512_DW,
   parameter int AF_LEVEL = RAM512_AF_LEVEL,
   parameter int AE_LEVEL = RAM512_AE_LEVEL
) (
   input  logic              Clk,
   input  logic              Rst,
   ram512_fifo_ctrl_if.slave fif,
   output logic [AW-1:0]     ram_wa,
   output logic [DW-1:0]     ram_wd,
   output logic              ram_wen,
   output logic              ram_wclk_en,
   output logic [AW-1:0]     ram_ra,
   output logic              ram_rclk_en,
   input  logic [DW-1:0]     ram_rd
);
   logic          push_ok, pop_ok;
   logic [AW:0]   wptr, wptr_nxt, rptr, rptr_nxt;
   logic [AW:0]   level_q, level_d;
   logic          full_q, full_d, empty_q, empty_d;
   logic          rd_valid_q, rd_valid_d;
   logic          ovf_q, ovf_d, udf_q, udf_d;
   logic [DW-1:0] rd_hold_q, rd_hold_d, rd_data_c;

   // Acceptance looks only at the registered flags of this cycle.
   always_comb begin
      push_ok = fif.push & ~full_q  & ~fif.flush;
      pop_ok  = fif.pop  & ~empty_q & ~fif.flush;
   end

   fifo_ptr_cnt #(.W(AW+1)) u_wptr (
      .clk(Clk), .rst(Rst), .clr(fif.flush), .inc(push_ok),
      .ptr(wptr), .ptr_nxt(wptr_nxt)
   );

   fifo_ptr_cnt #(.W(AW+1)) u_rptr (
      .clk(Clk), .rst(Rst), .clr(fif.flush), .inc(pop_ok),
      .ptr(rptr), .ptr_nxt(rptr_nxt)
   );

   always_comb begin
      ram_wa      = wptr[AW-1:0];
      ram_wd      = fif.wr_data;
      ram_wen     = push_ok;
      ram_wclk_en = push_ok;
      ram_ra      = rptr[AW-1:0];
      ram_rclk_en = pop_ok;
   end

   // The RAM output is live during the valid cycle, then held locally.
   assign rd_data_c = rd_valid_q ? ram_rd : rd_hold_q;

   always_comb begin
      level_d = level_q;
      if (fif.flush) level_d = '0;
      else           level_d = level_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
      full_d     = (wptr_nxt[AW] != rptr_nxt[AW]) && (wptr_nxt[AW-1:0] == rptr_nxt[AW-1:0]);
      empty_d    = (wptr_nxt == rptr_nxt);
      rd_valid_d = pop_ok;
      rd_hold_d  = rd_data_c;
      ovf_d      = (fif.push & full_q  & ~fif.flush) | (ovf_q & ~fif.clr_flags);
      udf_d      = (fif.pop  & empty_q & ~fif.flush) | (udf_q & ~fif.clr_flags);
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         level_q    <= '0;
         full_q     <= 1'b0;
         empty_q    <= 1'b1;
         rd_valid_q <= 1'b0;
         rd_hold_q  <= '0;
         ovf_q      <= 1'b0;
         udf_q      <= 1'b0;
      end else begin
         level_q    <= level_d;
         full_q     <= full_d;
         empty_q    <= empty_d;
         rd_valid_q <= rd_valid_d;
         rd_hold_q  <= rd_hold_d;
         ovf_q      <= ovf_d;
         udf_q      <= udf_d;
      end
   end

   assign fif.rd_data   = rd_data_c;
   assign fif.rd_valid  = rd_valid_q;
   assign fif.full      = full_q;
   assign fif.empty     = empty_q;
   assign fif.level     = level_q;
   assign fif.overflow  = ovf_q;
   assign fif.underflow = udf_q;

`ifdef RAM512_FIFO_ALMOST_FLAGS_EN
   localparam logic [AW:0] AF_LV = AF_LEVEL[AW:0];
   localparam logic [AW:0] AE_LV = AE_LEVEL[AW:0];

   logic afull_q, afull_d, aempty_q, aempty_d;

   always_comb begin
      afull_d  = (level_d >= AF_LV);
      aempty_d = (level_d <= AE_LV);
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         afull_q  <= 1'b0;
         aempty_q <= 1'b1;
      end else begin
         afull_q  <= afull_d;
         aempty_q <= aempty_d;
      end
   end

   assign fif.almost_full  = afull_q;
   assign fif.almost_empty = aempty_q;
`else
   localparam int unused_lvls = AF_LEVEL + AE_LEVEL;
`endif
endmodule

// File: tb/tb_ram512_fifo_ctrl.sv
// Randomized and directed bench for ram512_fifo_ctrl against a queue-based reference.
module tb_ram512_fifo_ctrl;
   localparam int AW    = 9;
   localparam int DW    = 8;
   localparam int DEPTH = 512;

   logic          Clk, Rst;
   logic [AW-1:0] ram_wa, ram_ra;
   logic [DW-1:0] ram_wd, ram_rd;
   logic          ram_wen, ram_wclk_en, ram_rclk_en;
   logic [DW-1:0] mem [DEPTH];

   ram512_fifo_ctrl_if f_if ();

   ram512_fifo_ctrl dut (
      .Clk(Clk), .Rst(Rst), .fif(f_if.slave),
      .ram_wa(ram_wa), .ram_wd(ram_wd), .ram_wen(ram_wen), .ram_wclk_en(ram_wclk_en),
      .ram_ra(ram_ra), .ram_rclk_en(ram_rclk_en), .ram_rd(ram_rd)
   );

   // Block RAM beside the controller: registered read.
   always @(posedge Clk) begin
      if (ram_wen && ram_wclk_en) mem[ram_wa] <= ram_wd;
      if (ram_rclk_en)            ram_rd      <= mem[ram_ra];
   end

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   int n_chk = 0;
   int n_err = 0;

   logic [DW-1:0] q [$];
   logic [DW-1:0] exp_dat;
   bit            exp_vld, exp_ovf, exp_udf;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_all();
      chk("level",     int'(f_if.level),     q.size());
      chk("empty",     int'(f_if.empty),     int'(q.size() == 0));
      chk("full",      int'(f_if.full),      int'(q.size() == DEPTH));
      chk("rd_valid",  int'(f_if.rd_valid),  int'(exp_vld));
      chk("rd_data",   int'(f_if.rd_data),   int'(exp_dat));
      chk("overflow",  int'(f_if.overflow),  int'(exp_ovf));
      chk("underflow", int'(f_if.underflow), int'(exp_udf));
`ifdef RAM512_FIFO_ALMOST_FLAGS_EN
      chk("almost_full",  int'(f_if.almost_full),  int'(q.size() >= 448));
      chk("almost_empty", int'(f_if.almost_empty), int'(q.size() <= 64));
`endif
   endtask

   task automatic model_reset();
      q.delete();
      exp_dat = '0;
      exp_vld = 0;
      exp_ovf = 0;
      exp_udf = 0;
   endtask

   // One clock: entered and left at posedge+1.
   task automatic cyc(input bit p, input logic [7:0] d, input bit o, input bit f, input bit c);
      int sz;
      bit pok, ook;
      f_if.push = p; f_if.wr_data = d; f_if.pop = o; f_if.flush = f; f_if.clr_flags = c;
      #1;
      sz  = q.size();
      pok = p && !f && sz < DEPTH;
      ook = o && !f && sz > 0;
      chk("ram_wen",     int'(ram_wen),     int'(pok));
      chk("ram_rclk_en", int'(ram_rclk_en), int'(ook));
      if (pok) chk("ram_wd", int'(ram_wd), int'(d));
      @(posedge Clk); #1;
      exp_vld = ook;
      if (ook) exp_dat = q.pop_front();
      if (pok) q.push_back(d);
      if (f) q.delete();
      if (c) begin exp_ovf = 0; exp_udf = 0; end
      if (p && !f && sz == DEPTH) exp_ovf = 1;
      if (o && !f && sz == 0)     exp_udf = 1;
      check_all();
   endtask

   initial begin
      Rst = 1'b1;
      f_if.push = 0; f_if.wr_data = '0; f_if.pop = 0; f_if.flush = 0; f_if.clr_flags = 0;
      model_reset();
      #3;
      check_all();
      @(negedge Clk) Rst = 1'b0;
      @(posedge Clk); #1;

      // random mixed traffic
      for (int i = 0; i < 300; i++)
         cyc($urandom_range(0, 2) != 0, 8'($urandom), $urandom_range(0, 2) == 0,
             $urandom_range(0, 60) == 0, $urandom_range(0, 40) == 0);

      // reset in the middle of a burst
      for (int i = 0; i < 20; i++) cyc(1, 8'($urandom), $urandom_range(0, 1) == 1, 0, 0);
      f_if.push = 1; f_if.pop = 1;
      #2 Rst = 1'b1;
      #1;
      model_reset();
      check_all();
      f_if.push = 0; f_if.pop = 0;
      @(negedge Clk) Rst = 1'b0;
      @(posedge Clk); #1;
      check_all();

      // fill with two ramps, overflow, clear, drain (wraps 511->0)
      for (int i = 0; i < DEPTH; i++) cyc(1, 8'(i), 0, 0, 0);
      cyc(1, 8'hAA, 0, 0, 0);
      cyc(0, 8'h00, 0, 0, 1);
      for (int i = 0; i < DEPTH; i++) cyc(0, 8'h00, 1, 0, 0);
      cyc(0, 8'h00, 0, 0, 0);

      // empty-side boundaries
      cyc(0, 8'h00, 1, 0, 0);
      cyc(0, 8'h00, 0, 0, 0);
      cyc(0, 8'h00, 0, 0, 1);
      cyc(1, 8'h5A, 1, 0, 0);
      cyc(0, 8'h00, 0, 0, 1);

      // full-side push+pop
      for (int i = 1; i < DEPTH; i++) cyc(1, 8'($urandom), 0, 0, 0);
      cyc(1, 8'h11, 1, 0, 0);
      cyc(0, 8'h00, 0, 0, 1);

      // steady streaming at level 100
      cyc(0, 8'h00, 0, 1, 0);
      for (int i = 0; i < 100; i++) cyc(1, 8'($urandom), 0, 0, 0);
      for (int i = 0; i < 1000; i++) cyc(1, 8'($urandom), 1, 0, 0);
      cyc(0, 8'h00, 0, 0, 0);

      // flush beats simultaneous push and pop
      cyc(0, 8'h00, 0, 1, 0);
      for (int i = 0; i < 37; i++) cyc(1, 8'($urandom), 0, 0, 0);
      cyc(1, 8'h77, 1, 1, 0);
      cyc(0, 8'h00, 1, 0, 0);

      // pop in flight completes across a flush
      cyc(1, 8'h3C, 0, 0, 0);
      cyc(1, 8'h4D, 1, 0, 0);
      cyc(0, 8'h00, 0, 1, 0);

      for (int i = 0; i < 300; i++)
         cyc($urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 1) == 1,
             $urandom_range(0, 80) == 0, $urandom_range(0, 40) == 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
